// File: rtl/line_streamer_pkg.sv
// Shared types for the line streamer: FSM states, default widths, FIFO entry layout.
// No logic of its own.
// No backpressure of its own.
package line_streamer_pkg;

    localparam int LS_ADDR_W = 8;
    localparam int LS_LEN_W  = 8;
    localparam int LS_CHAR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Address driven on the memory port whenever no read is issued.
    localparam logic [LS_ADDR_W-1:0] ADDR_PARK = '1;

    // One captured character pair at the default widths; the top re-declares
    // the same layout at its own parameter widths when overridden.
    typedef struct packed {
        logic [LS_CHAR_W-1:0] lhs;
        logic [LS_CHAR_W-1:0] rhs;
        logic [LS_LEN_W-1:0]  index;
        logic                 last;
    } fifo_entry_t;

endpackage

// File: rtl/streamer_skid_fifo.sv
// Two-entry synchronous FIFO holding captured character pairs ahead of the output port.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: never refuses; the caller keeps pushes within capacity, push+pop may coincide at any occupancy.
module streamer_skid_fifo
    import line_streamer_pkg::*;
#(
    parameter type entry_t = fifo_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  entry_t     push_dat_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output logic       head_vld_o,
    output entry_t     head_dat_o
);

    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_pop;

    assign do_pop     = pop_i && (count_q != 2'd0);
    assign count_o    = count_q;
    assign head_vld_o = (count_q != 2'd0);
    assign head_dat_o = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; a pop at full frees the slot the push reuses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push_i) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/line_streamer.sv
// Walks one line of a 1-cycle-latency character memory and streams (lhs, rhs) pairs with index/last tags.
// Latency: first out_valid two edges after the descriptor is accepted; one beat per cycle while out_ready is high.
// Backpressure: reads stop once in-flight plus queued pairs reach two, so the skid FIFO never overflows.
module line_streamer
    import line_streamer_pkg::*;
#(
    parameter int ADDR_W = LS_ADDR_W,
    parameter int LEN_W  = LS_LEN_W,
    parameter int CHAR_W = LS_CHAR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_start,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_reverse,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [2*CHAR_W-1:0] mem_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHAR_W-1:0]   out_lhs,
    output logic [CHAR_W-1:0]   out_rhs,
    output logic [LEN_W-1:0]    out_index,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                wrapped
);

    // Extra bit catches start+len-1 running past the top of the address space.
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam logic [ADDR_W-1:0] PARK = '1;

    typedef struct packed {
        logic [CHAR_W-1:0] lhs;
        logic [CHAR_W-1:0] rhs;
        logic [LEN_W-1:0]  index;
        logic              last;
    } entry_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic              rev_q, rev_d;
    logic              wrapped_q, wrapped_d;
    logic              rd_vld_q;
    logic [LEN_W-1:0]  rd_idx_q;
    logic              rd_last_q;

    logic [SUM_W-1:0]  end_ext;
    logic              start_wrap;
    logic [ADDR_W-1:0] first_addr;
    logic [1:0]        fifo_count;
    logic [1:0]        pending;
    logic              head_vld;
    entry_t            head_dat;
    entry_t            push_dat;
    logic              pop;
    logic              issue;
    logic              is_last_issue;

    assign end_ext    = SUM_W'(cmd_start) + SUM_W'(cmd_len) - SUM_W'(1);
    assign start_wrap = |end_ext[SUM_W-1:ADDR_W];
    assign first_addr = cmd_reverse ? end_ext[ADDR_W-1:0] : cmd_start;

    // A pair leaving the FIFO this cycle frees its slot in time for the read issued now,
    // which is what keeps the stream at one beat per cycle under no backpressure.
    assign pop           = head_vld && out_ready;
    assign pending       = 2'(rd_vld_q) + fifo_count - 2'(pop);
    assign issue         = (state_q == FETCH) && (pending < 2'd2) && (issued_q < len_q);
    assign is_last_issue = (issued_q == len_q - LEN_W'(1));

    assign mem_en   = issue;
    assign mem_addr = issue ? addr_q : PARK;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == FETCH) || (state_q == DRAIN);
    assign done      = (state_q == FINISH);
    assign wrapped   = wrapped_q;

    assign push_dat = '{lhs:   mem_dout[2*CHAR_W-1:CHAR_W],
                        rhs:   mem_dout[CHAR_W-1:0],
                        index: rd_idx_q,
                        last:  rd_last_q};

    streamer_skid_fifo #(
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rd_vld_q),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .count_o    (fifo_count),
        .head_vld_o (head_vld),
        .head_dat_o (head_dat)
    );

    assign out_valid = head_vld;
    assign out_lhs   = head_dat.lhs;
    assign out_rhs   = head_dat.rhs;
    assign out_index = head_dat.index;
    assign out_last  = head_dat.last;

    // Next-state: descriptor latch, read address walk, wrap detection and line sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rev_d     = rev_q;
        issued_d  = issued_q;
        wrapped_d = wrapped_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d     = cmd_len;
                    rev_d     = cmd_reverse;
                    addr_d    = first_addr;
                    issued_d  = '0;
                    wrapped_d = cmd_reverse && (cmd_len != '0) && start_wrap;
                    state_d   = (cmd_len == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    issued_d = issued_q + LEN_W'(1);
                    addr_d   = rev_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
                    // Only a step between two issued addresses counts as a wrap.
                    if ((issued_q != '0) &&
                        ((!rev_q && (addr_q == '0)) || (rev_q && (addr_q == PARK)))) begin
                        wrapped_d = 1'b1;
                    end
                    if (is_last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_dat.last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers plus the tag of the read whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rev_q     <= 1'b0;
            issued_q  <= '0;
            wrapped_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rev_q     <= rev_d;
            issued_q  <= issued_d;
            wrapped_q <= wrapped_d;
            rd_vld_q  <= issue;
            rd_idx_q  <= issued_q;
            rd_last_q <= is_last_issue;
        end
    end

endmodule
